// File: rtl/signed_min_tracker_pkg.sv
// Shared types and defaults for the signed minimum tracker.
package signed_min_tracker_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned IDX_W_DEF   = 16;
  localparam int unsigned CNT_SAT_DEF = (1 << IDX_W_DEF) - 1;

endpackage

// File: rtl/signed_min_tracker_cmp.sv
// Combinational two's-complement strict less-than comparator.
module signed_lt_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt
);

  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/signed_min_tracker.sv
// Per-frame signed minimum, first index of the minimum and saturating word count
// over a valid/ready stream; one result per frame on a valid/ready output.
module signed_min_tracker
  import signed_min_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [IDX_W-1:0] SAT = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] cur_min, min_n;
  logic [IDX_W-1:0] cur_idx, idx_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic             lt;

  signed_lt_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (in_data),
    .b  (cur_min),
    .lt (lt)
  );

  // Ready is held low while reset is asserted; otherwise only the registered state matters.
  assign in_ready  = !rst && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_min   = cur_min;
  assign out_idx   = cur_idx;
  assign out_count = cnt;
  assign out_ovf   = ovf;

  always_comb begin
    state_n = state;
    min_n   = cur_min;
    idx_n   = cur_idx;
    cnt_n   = cnt;
    ovf_n   = ovf;
    unique case (state)
      EMPTY: begin
        if (in_valid) begin
          min_n   = in_data;
          idx_n   = '0;
          cnt_n   = IDX_W'(1);
          ovf_n   = 1'b0;
          state_n = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (cnt == SAT) ovf_n = 1'b1;
          else            cnt_n = cnt + 1'b1;
          // Once the count is pinned the index can no longer be trusted, so it freezes.
          if (lt) begin
            min_n = in_data;
            if (cnt != SAT) idx_n = cnt;
          end
          if (in_last) state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = EMPTY;
          min_n   = '0;
          idx_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      cur_min <= '0;
      cur_idx <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      cur_min <= min_n;
      cur_idx <= idx_n;
      cnt     <= cnt_n;
      ovf     <= ovf_n;
    end
  end

endmodule
